// File: rtl/datapath_ctrl_pkg.sv
// datapath_ctrl_pkg: shared encodings, field positions and FSM states for the datapath sequencer
package datapath_ctrl_pkg;
  localparam int INSTR_W = 12;
  localparam int KIND_HI = 11;
  localparam int KIND_LO = 10;
  localparam int ALU_HI = 9;
  localparam int ALU_LO = 7;
  localparam int RD_HI = 6;
  localparam int RD_LO = 5;
  localparam int RS1_HI = 4;
  localparam int RS1_LO = 3;
  localparam int RS2_HI = 2;
  localparam int RS2_LO = 1;
  localparam int COND_BIT = 0;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  typedef enum logic [1:0] {
    KIND_ALU  = 2'b00,
    KIND_CMP  = 2'b01,
    KIND_NOP  = 2'b10,
    KIND_HALT = 2'b11
  } kind_e;
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_READ   = 3'd1,
    S_EXEC   = 3'd2,
    S_SKIP   = 3'd3,
    S_HALTED = 3'd4
  } state_e;
endpackage

// File: rtl/dp_instr_decode.sv
// dp_instr_decode: splits a micro-instruction word into datapath control fields
module dp_instr_decode
  import datapath_ctrl_pkg::*;
(
  input  logic [INSTR_W-1:0] ir,
  output kind_e              kind,
  output logic [2:0]         alu_op,
  output logic [1:0]         rd,
  output logic [1:0]         rs1,
  output logic [1:0]         rs2,
  output logic               cond,
  output logic               is_write,
  output logic               updates_zero
);
  assign kind = kind_e'(ir[KIND_HI:KIND_LO]);
  assign alu_op = ir[ALU_HI:ALU_LO];
  assign rd = ir[RD_HI:RD_LO];
  assign rs1 = ir[RS1_HI:RS1_LO];
  assign rs2 = ir[RS2_HI:RS2_LO];
  assign cond = ir[COND_BIT];
  assign is_write = kind == KIND_ALU;
  assign updates_zero = kind == KIND_ALU || kind == KIND_CMP;
endmodule

// File: rtl/datapath_sequencer.sv
// datapath_sequencer: multi-cycle controller sequencing the register-file/ALU datapath
module datapath_sequencer
  import datapath_ctrl_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [INSTR_W-1:0] instr,
  input  logic               resume,
  input  logic               zero_flag,
  output logic [1:0]         read_reg_num1,
  output logic [1:0]         read_reg_num2,
  output logic [1:0]         write_reg,
  output logic [2:0]         alu_control,
  output logic               regwrite,
  output logic               busy,
  output logic               halted,
  output logic               done,
  output logic               skipped,
  output logic               zero_status,
  output logic [CNT_W-1:0]   retired_count
);
  state_e      state;
  kind_e       kind;
  logic [2:0]  alu_op;
  logic [1:0]  rd, rs1, rs2;
  logic        cond, is_write, updates_zero, wr_q, uz_q;
  logic        accept;
  dp_instr_decode u_dec (
    .ir           (instr),
    .kind         (kind),
    .alu_op       (alu_op),
    .rd           (rd),
    .rs1          (rs1),
    .rs2          (rs2),
    .cond         (cond),
    .is_write     (is_write),
    .updates_zero (updates_zero)
  );
  assign accept = instr_valid && instr_ready;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      read_reg_num1 <= '0;
      read_reg_num2 <= '0;
      write_reg <= '0;
      alu_control <= '0;
      wr_q <= 1'b0;
      uz_q <= 1'b0;
      instr_ready <= 1'b1;
      regwrite <= 1'b0;
      busy <= 1'b0;
      halted <= 1'b0;
      done <= 1'b0;
      skipped <= 1'b0;
      zero_status <= 1'b0;
      retired_count <= '0;
    end else begin
      done <= 1'b0;
      skipped <= 1'b0;
      regwrite <= 1'b0;
      if (accept) begin
        read_reg_num1 <= rs1;
        read_reg_num2 <= rs2;
        write_reg <= rd;
        alu_control <= alu_op;
        wr_q <= is_write;
        uz_q <= updates_zero;
      end
      case (state)
        S_IDLE: if (accept) begin
          instr_ready <= 1'b0;
          if (kind == KIND_HALT) begin
            state <= S_HALTED;
            halted <= 1'b1;
            done <= 1'b1;
            retired_count <= retired_count + 1'b1;
          end else begin
            state <= (cond && !zero_status) ? S_SKIP : S_READ;
            busy <= 1'b1;
          end
        end
        S_READ: begin
          state <= S_EXEC;
          regwrite <= wr_q;
        end
        S_EXEC, S_SKIP: begin
          state <= S_IDLE;
          busy <= 1'b0;
          instr_ready <= 1'b1;
          done <= 1'b1;
          skipped <= state == S_SKIP;
          retired_count <= retired_count + 1'b1;
          if (state == S_EXEC && uz_q) zero_status <= zero_flag;
        end
        S_HALTED: if (resume) begin
          state <= S_IDLE;
          halted <= 1'b0;
          instr_ready <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_datapath_sequencer.sv
// tb_datapath_sequencer: directed self-checking bench for the datapath sequencer
module tb_datapath_sequencer;
  import datapath_ctrl_pkg::*;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        instr_valid = 1'b0;
  logic [11:0] instr = '0;
  logic        resume = 1'b0;
  logic        zero_flag = 1'b0;
  logic        instr_ready, regwrite, busy, halted, done, skipped, zero_status;
  logic [1:0]  read_reg_num1, read_reg_num2, write_reg;
  logic [2:0]  alu_control;
  logic [7:0]  retired_count;
  int          errs = 0;
  int          checks = 0;
  datapath_sequencer #(.CNT_W(8)) dut (
    .clock         (clock),
    .reset         (reset),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr         (instr),
    .resume        (resume),
    .zero_flag     (zero_flag),
    .read_reg_num1 (read_reg_num1),
    .read_reg_num2 (read_reg_num2),
    .write_reg     (write_reg),
    .alu_control   (alu_control),
    .regwrite      (regwrite),
    .busy          (busy),
    .halted        (halted),
    .done          (done),
    .skipped       (skipped),
    .zero_status   (zero_status),
    .retired_count (retired_count)
  );
  always #5 clock = ~clock;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clock);
    #1;
  endtask
  task automatic issue(input logic [11:0] word);
    instr = word;
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
  endtask
  initial begin
    int bad, dones, last;
    #1 reset = 1'b0;
    #2;
    check("rst_ready", instr_ready, 1);
    check("rst_regwrite", regwrite, 0);
    check("rst_busy", busy, 0);
    check("rst_halted", halted, 0);
    check("rst_done", done, 0);
    check("rst_zs", zero_status, 0);
    check("rst_count", retired_count, 0);
    check("rst_fields", {read_reg_num1, read_reg_num2, write_reg, alu_control}, 0);
    tick();
    reset = 1'b1;
    tick();
    zero_flag = 1'b1;
    issue(12'h70A);
    check("cmp_c1_busy", busy, 1);
    check("cmp_c1_ready", instr_ready, 0);
    check("cmp_c1_rs", {read_reg_num1, read_reg_num2}, 4'b0101);
    check("cmp_c1_alu", alu_control, ALU_SUB);
    check("cmp_c1_rw", regwrite, 0);
    tick();
    check("cmp_c2_rw", regwrite, 0);
    check("cmp_c2_done", done, 0);
    tick();
    check("cmp_c3_done", done, 1);
    check("cmp_c3_skip", skipped, 0);
    check("cmp_c3_zs", zero_status, 1);
    check("cmp_c3_count", retired_count, 1);
    check("cmp_c3_ready", instr_ready, 1);
    zero_flag = 1'b0;
    issue(12'h143);
    check("add_c1_rw", regwrite, 0);
    tick();
    check("add_c2_rw", regwrite, 1);
    check("add_c2_wr", write_reg, 2);
    check("add_c2_alu", alu_control, ALU_ADD);
    check("add_c2_rs", {read_reg_num1, read_reg_num2}, 4'b0001);
    tick();
    check("add_c3_done", done, 1);
    check("add_c3_rw", regwrite, 0);
    check("add_c3_zs", zero_status, 0);
    check("add_c3_count", retired_count, 2);
    issue(12'h143);
    check("skip_c1_busy", busy, 1);
    check("skip_c1_rw", regwrite, 0);
    check("skip_c1_done", done, 0);
    tick();
    check("skip_c2_done", done, 1);
    check("skip_c2_skipped", skipped, 1);
    check("skip_c2_rw", regwrite, 0);
    check("skip_c2_count", retired_count, 3);
    check("skip_c2_ready", instr_ready, 1);
    tick();
    check("skip_c3_done", done, 0);
    check("skip_c3_skipped", skipped, 0);
    issue(12'h142);
    tick();
    check("mid_exec_rw", regwrite, 1);
    reset = 1'b0;
    #1;
    check("mid_rst_rw", regwrite, 0);
    check("mid_rst_count", retired_count, 0);
    check("mid_rst_ready", instr_ready, 1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_fields", {read_reg_num1, read_reg_num2, write_reg, alu_control}, 0);
    #18;
    reset = 1'b1;
    tick();
    check("post_rst_rw", regwrite, 0);
    check("post_rst_done", done, 0);
    instr = 12'hC00;
    instr_valid = 1'b1;
    tick();
    instr = 12'h800;
    check("halt_halted", halted, 1);
    check("halt_done", done, 1);
    check("halt_ready", instr_ready, 0);
    check("halt_count", retired_count, 1);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (i == 5) instr = 12'h860;
      tick();
      if (instr_ready !== 1'b0 || done !== 1'b0 || halted !== 1'b1 || write_reg !== 2'd0) bad++;
    end
    check("halt_hold", bad, 0);
    resume = 1'b1;
    tick();
    resume = 1'b0;
    check("resume_halted", halted, 0);
    check("resume_ready", instr_ready, 1);
    tick();
    instr_valid = 1'b0;
    check("held_busy", busy, 1);
    check("held_wr", write_reg, 3);
    tick();
    tick();
    check("held_done", done, 1);
    check("held_count", retired_count, 2);
    reset = 1'b0;
    #2;
    reset = 1'b1;
    zero_flag = 1'b1;
    instr = 12'h800;
    instr_valid = 1'b1;
    dones = 0;
    last = -1;
    bad = 0;
    for (int c = 0; c < 900 && dones < 256; c++) begin
      tick();
      if (done) begin
        if (last >= 0 && c - last != 3) bad++;
        last = c;
        dones++;
      end
    end
    instr_valid = 1'b0;
    check("wrap_dones", dones, 256);
    check("wrap_spacing", bad, 0);
    check("wrap_count", retired_count, 0);
    check("wrap_zs", zero_status, 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
